// File: rtl/winograd_output_scheduler.sv
// Output-stage sequencer for Winograd F(4x4,3x3). For each output tile it gathers the
// 6x6 product tile, launches the reverse transform, and scatters the clipped 4x4 result.
module winograd_output_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int TB_ADDR_WIDTH  = 18,
  parameter int RES_ADDR_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [7:0]                        out_rows,
  input  logic [7:0]                        out_cols,
  output logic                              busy,
  output logic                              done,
  output logic                              tb_rd_en,
  output logic [TB_ADDR_WIDTH-1:0]          tb_rd_addr,
  input  logic [DATA_WIDTH-1:0]             tb_rd_data,
  output logic [0:5][0:5][DATA_WIDTH-1:0]   rtu_matrix_in,
  output logic                              rtu_start,
  input  logic [0:3][0:3][DATA_WIDTH-1:0]   rtu_matrix_out,
  input  logic                              rtu_done,
  output logic                              res_wr_en,
  output logic [RES_ADDR_WIDTH-1:0]         res_wr_addr,
  output logic [DATA_WIDTH-1:0]             res_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t state, state_d;

  logic [7:0]                       rows_q, cols_q;
  logic [6:0]                       tiles_h_q, tiles_w_q;
  logic [5:0]                       ty, tx;
  logic [TB_ADDR_WIDTH-1:0]         tile_base;
  logic [2:0]                       rd_r, rd_c;     // element of the read on the bus
  logic                             cap_v;
  logic [2:0]                       cap_r, cap_c;   // element whose datum arrives this cycle
  logic [0:3][0:3][DATA_WIDTH-1:0]  res_q;
  logic [4:0]                       st_n;

  logic zero_dims, last_rd, last_cap, last_tx, last_ty, wr_slot, sel_keep;
  logic [3:0]            sel_n;
  logic [8:0]            sel_row, sel_col;
  logic [17:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign zero_dims = (out_rows == 8'd0) || (out_cols == 8'd0);
  assign last_rd   = (rd_r == 3'd5) && (rd_c == 3'd5);
  assign last_cap  = cap_v && (cap_r == 3'd5) && (cap_c == 3'd5);
  assign last_tx   = ({1'b0, tx} == tiles_w_q - 7'd1);
  assign last_ty   = ({1'b0, ty} == tiles_h_q - 7'd1);
  assign wr_slot   = ((state == S_WAIT) && rtu_done) || ((state == S_STORE) && (st_n != 5'd16));

  // Element 0 is written on the rtu_done edge straight from the transform outputs.
  always_comb begin
    sel_n    = (state == S_STORE) ? st_n[3:0] : 4'd0;
    sel_row  = {1'b0, ty, 2'b00} + 9'(sel_n[3:2]);
    sel_col  = {1'b0, tx, 2'b00} + 9'(sel_n[1:0]);
    sel_keep = (sel_row < {1'b0, rows_q}) && (sel_col < {1'b0, cols_q});
    sel_addr = 18'(sel_row) * 18'(cols_q) + 18'(sel_col);
    sel_data = (state == S_STORE) ? res_q[sel_n[3:2]][sel_n[1:0]] : rtu_matrix_out[0][0];
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = zero_dims ? S_DONE : S_LOAD;
      S_LOAD:   if (last_cap) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (rtu_done) state_d = S_STORE;
      S_STORE:  if (st_n == 5'd16) state_d = S_NEXT;
      S_NEXT:   state_d = (last_tx && last_ty) ? S_DONE : S_LOAD;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: strobes are decoded from state_d so they are registered yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      tb_rd_en    <= 1'b0;
      rtu_start   <= 1'b0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
    end else begin
      state     <= state_d;
      busy      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done      <= (state_d == S_DONE);
      rtu_start <= (state_d == S_LAUNCH);
      tb_rd_en  <= ((state != S_LOAD) && (state_d == S_LOAD)) ||
                   ((state == S_LOAD) && tb_rd_en && !last_rd);
      res_wr_en <= wr_slot && sel_keep;
      if (wr_slot && sel_keep) begin
        res_wr_addr <= RES_ADDR_WIDTH'(sel_addr);
        res_wr_data <= sel_data;
      end
    end
  end

  // NOTE: the 6x6 and 4x4 holding registers are reset too, so every output reads 0 after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q        <= '0;
      cols_q        <= '0;
      tiles_h_q     <= '0;
      tiles_w_q     <= '0;
      ty            <= '0;
      tx            <= '0;
      tile_base     <= '0;
      tb_rd_addr    <= '0;
      rd_r          <= '0;
      rd_c          <= '0;
      cap_v         <= 1'b0;
      cap_r         <= '0;
      cap_c         <= '0;
      rtu_matrix_in <= '0;
      res_q         <= '0;
      st_n          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !zero_dims) begin
            rows_q     <= out_rows;
            cols_q     <= out_cols;
            tiles_h_q  <= 7'((9'(out_rows) + 9'd3) >> 2);
            tiles_w_q  <= 7'((9'(out_cols) + 9'd3) >> 2);
            ty         <= '0;
            tx         <= '0;
            tile_base  <= '0;
            tb_rd_addr <= '0;
            rd_r       <= '0;
            rd_c       <= '0;
          end
        end
        S_LOAD: begin
          if (tb_rd_en && !last_rd) begin
            tb_rd_addr <= tb_rd_addr + TB_ADDR_WIDTH'(1);
            if (rd_c == 3'd5) begin
              rd_c <= '0;
              rd_r <= rd_r + 3'd1;
            end else begin
              rd_c <= rd_c + 3'd1;
            end
          end
          cap_v <= tb_rd_en;
          cap_r <= rd_r;
          cap_c <= rd_c;
          if (cap_v) rtu_matrix_in[cap_r][cap_c] <= tb_rd_data;
        end
        S_WAIT: begin
          if (rtu_done) begin
            res_q <= rtu_matrix_out;
            st_n  <= 5'd1;
          end
        end
        S_STORE: begin
          if (st_n != 5'd16) st_n <= st_n + 5'd1;
        end
        S_NEXT: begin
          tile_base  <= tile_base + TB_ADDR_WIDTH'(36);
          tb_rd_addr <= tile_base + TB_ADDR_WIDTH'(36);
          rd_r       <= '0;
          rd_c       <= '0;
          if (last_tx) begin
            tx <= '0;
            ty <= ty + 6'd1;
          end else begin
            tx <= tx + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_output_scheduler.sv
// Scoreboard bench for winograd_output_scheduler: tile-buffer model, stub reverse
// transform with programmable latency, and queue-checked read/write traffic.
module tb_winograd_output_scheduler;

  logic                     clk = 1'b0;
  logic                     rst, start;
  logic [7:0]               out_rows, out_cols;
  logic                     busy, done, tb_rd_en, rtu_start, res_wr_en;
  logic [17:0]              tb_rd_addr;
  logic [15:0]              tb_rd_data = '0;
  logic [0:5][0:5][15:0]    rtu_matrix_in;
  logic [0:3][0:3][15:0]    rtu_matrix_out;
  logic                     rtu_done, rtu_done_stub, rtu_done_inj;
  logic [15:0]              res_wr_addr, res_wr_data;

  assign rtu_done = rtu_done_stub | rtu_done_inj;

  winograd_output_scheduler #(.DATA_WIDTH(16), .TB_ADDR_WIDTH(18), .RES_ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .out_rows(out_rows), .out_cols(out_cols),
    .busy(busy), .done(done), .tb_rd_en(tb_rd_en), .tb_rd_addr(tb_rd_addr),
    .tb_rd_data(tb_rd_data), .rtu_matrix_in(rtu_matrix_in), .rtu_start(rtu_start),
    .rtu_matrix_out(rtu_matrix_out), .rtu_done(rtu_done), .res_wr_en(res_wr_en),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [15:0] data; } wr_t;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  int          rtu_lat = 1;
  int          rd_cnt, wr_cnt, done_cnt, busy_cnt, rs_cnt, first_rd, first_rs, done_cyc;
  int          rd_q[$];
  wr_t         wr_q[$];
  logic [15:0] tbuf [256];
  logic [15:0] res_mem [256];
  logic [15:0] res_snap [256];
  int          hits [256];
  int          at_m [4][6] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                               '{0, 1, 1, 4, 4, 0}, '{0, 1, -1, 8, -8, 1}};
  logic [15:0] cb_exp [16] = '{16'd1, 16'hFFFF, 16'd1, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFF, 16'd1,
                               16'd1, 16'hFFFF, 16'd1, 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFF, 16'd1};
  logic [15:0] ones_exp [16] = '{16'd25, 16'd0, 16'd50, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0,
                                 16'd50, 16'd0, 16'd100, 16'd10, 16'd5, 16'd0, 16'd10, 16'd1};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (tb_rd_en) tb_rd_data <= tbuf[tb_rd_addr[7:0]];

  function automatic void xform(input logic [0:5][0:5][15:0] m, output logic [0:3][0:3][15:0] y);
    int t [4][6];
    int s;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 6; c++) begin
        t[i][c] = 0;
        for (int r = 0; r < 6; r++) t[i][c] += at_m[i][r] * int'($signed(m[r][c]));
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int c = 0; c < 6; c++) s += t[i][c] * at_m[j][c];
        y[i][j] = 16'(s);
      end
  endfunction

  // Stub reverse transform: samples rtu_start mid-cycle, answers rtu_lat cycles later.
  initial begin
    logic [0:3][0:3][15:0] y_stub;
    rtu_done_stub  = 1'b0;
    rtu_matrix_out = '0;
    forever begin
      @(negedge clk);
      if (rtu_start === 1'b1) begin
        xform(rtu_matrix_in, y_stub);
        repeat (rtu_lat) @(negedge clk);
        rtu_matrix_out = y_stub;
        rtu_done_stub  = 1'b1;
        @(negedge clk);
        rtu_done_stub  = 1'b0;
        rtu_matrix_out = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every read and write strobe.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (rtu_start === 1'b1) begin
      rs_cnt++;
      if (first_rs < 0) first_rs = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tb_rd_en === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got addr %0d, none expected (cyc %0d)", tb_rd_addr, cyc);
      end else begin
        int ea;
        ea = rd_q.pop_front();
        if (tb_rd_addr !== 18'(ea)) begin
          n_err++;
          $display("FAIL rd_addr: got %0d, want %0d (cyc %0d)", tb_rd_addr, ea, cyc);
        end
      end
    end
    if (res_wr_en === 1'b1) begin
      wr_cnt++;
      n_vec++;
      if (wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr %0d data %0h (cyc %0d)", res_wr_addr, res_wr_data, cyc);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (res_wr_addr !== 16'(e.addr) || res_wr_data !== e.data) begin
          n_err++;
          $display("FAIL wr: got addr %0d data %0h, want addr %0d data %0h (cyc %0d)",
                   res_wr_addr, res_wr_data, e.addr, e.data, cyc);
        end
      end
      if (res_wr_addr < 16'd256) begin
        res_mem[res_wr_addr[7:0]] = res_wr_data;
        hits[res_wr_addr[7:0]]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_state();
    for (int a = 0; a < 256; a++) begin
      tbuf[a] = '0;
      res_mem[a] = 'x;
      hits[a] = 0;
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  // Expected reads for every tile; expected writes from the model when with_writes is set.
  task automatic push_plane(input int rows, input int cols, input bit with_writes);
    logic [0:5][0:5][15:0] m;
    logic [0:3][0:3][15:0] y;
    int th, tw, base;
    th = (rows + 3) / 4;
    tw = (cols + 3) / 4;
    for (int ty = 0; ty < th; ty++)
      for (int tx = 0; tx < tw; tx++) begin
        base = (ty * tw + tx) * 36;
        for (int k = 0; k < 36; k++) begin
          rd_q.push_back(base + k);
          m[k / 6][k % 6] = tbuf[base + k];
        end
        if (with_writes) begin
          xform(m, y);
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              if (ty * 4 + i < rows && tx * 4 + j < cols)
                wr_q.push_back('{(ty * 4 + i) * cols + tx * 4 + j, y[i][j]});
        end
      end
  endtask

  task automatic pulse_start(input logic [7:0] r, input logic [7:0] c, output int t0);
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0; rs_cnt = 0;
    first_rd = -1; first_rs = -1; done_cyc = -1;
    out_rows = r; out_cols = c; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, tb_rd_en, rtu_start, res_wr_en} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, want 00000", {busy, done, tb_rd_en, rtu_start, res_wr_en});
    end
    n_vec++;
    if (tb_rd_addr !== 18'd0 || res_wr_addr !== 16'd0 || res_wr_data !== 16'd0) begin
      n_err++;
      $display("FAIL reset_addr_data: got %0h/%0h/%0h, want 0/0/0", tb_rd_addr, res_wr_addr, res_wr_data);
    end
    n_vec++;
    if (rtu_matrix_in !== '0) begin
      n_err++;
      $display("FAIL reset_matrix: got nonzero rtu_matrix_in, want 0");
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, tb_rd_en} !== 3'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b, want 000", {busy, done, tb_rd_en});
    end
  endtask

  task automatic test_impulse();
    int t0;
    clear_state();
    rtu_lat = 1;
    tbuf[2 * 6 + 2] = 16'd1;
    push_plane(4, 4, 1'b0);
    for (int n = 0; n < 16; n++) wr_q.push_back('{n, cb_exp[n]});
    pulse_start(8'd4, 8'd4, t0);
    wait_done(500);
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL impulse_done_count: got %0d, want 1", done_cnt); end
    n_vec++;
    if (first_rd !== t0 + 1) begin n_err++; $display("FAIL impulse_first_read: got %0d, want %0d", first_rd, t0 + 1); end
    n_vec++;
    if (first_rs !== t0 + 38 || rs_cnt !== 1) begin
      n_err++;
      $display("FAIL impulse_rtu_start: got cyc %0d count %0d, want cyc %0d count 1", first_rs, rs_cnt, t0 + 38);
    end
    n_vec++;
    if (done_cyc !== t0 + 57) begin n_err++; $display("FAIL impulse_done_time: got %0d, want %0d", done_cyc, t0 + 57); end
    n_vec++;
    if (busy_cnt !== done_cyc - t0 - 1) begin
      n_err++;
      $display("FAIL impulse_busy_span: got %0d cycles, want %0d", busy_cnt, done_cyc - t0 - 1);
    end
    n_vec++;
    if (wr_cnt !== 16 || rd_cnt !== 36 || wr_q.size() !== 0) begin
      n_err++;
      $display("FAIL impulse_counts: got wr %0d rd %0d left %0d, want 16 36 0", wr_cnt, rd_cnt, wr_q.size());
    end
  endtask

  task automatic test_ones();
    int t0;
    clear_state();
    rtu_lat = 3;
    for (int k = 0; k < 36; k++) tbuf[k] = 16'd1;
    push_plane(4, 4, 1'b0);
    for (int n = 0; n < 16; n++) wr_q.push_back('{n, ones_exp[n]});
    pulse_start(8'd4, 8'd4, t0);
    wait_done(500);
    n_vec++;
    if (done_cnt !== 1 || wr_cnt !== 16 || wr_q.size() !== 0) begin
      n_err++;
      $display("FAIL ones_counts: got done %0d wr %0d left %0d, want 1 16 0", done_cnt, wr_cnt, wr_q.size());
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 144; a++) tbuf[a] = 16'($urandom_range(0, 40)) - 16'd20;
  endtask

  task automatic test_edge_clip();
    int t0, bad;
    clear_state();
    rtu_lat = 1;
    fill_random();
    push_plane(6, 5, 1'b1);
    pulse_start(8'd6, 8'd5, t0);
    wait_done(1000);
    bad = 0;
    for (int a = 0; a < 30; a++) if (hits[a] != 1) bad++;
    for (int a = 30; a < 256; a++) if (hits[a] != 0) bad++;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL clip_coverage: got %0d bad addrs, want 0", bad); end
    n_vec++;
    if (wr_cnt !== 30 || rd_cnt !== 144 || rs_cnt !== 4 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL clip_counts: got wr %0d rd %0d rs %0d done %0d, want 30 144 4 1", wr_cnt, rd_cnt, rs_cnt, done_cnt);
    end
    n_vec++;
    if (wr_q.size() !== 0 || rd_q.size() !== 0) begin
      n_err++;
      $display("FAIL clip_leftover: got %0d writes %0d reads pending, want 0 0", wr_q.size(), rd_q.size());
    end
    for (int a = 0; a < 256; a++) res_snap[a] = res_mem[a];
  endtask

  // Same plane as test_edge_clip at latency 20, with a stray start and a stray rtu_done.
  task automatic test_latency();
    int t0, diff;
    rd_q.delete();
    wr_q.delete();
    for (int a = 0; a < 256; a++) begin
      res_mem[a] = 'x;
      hits[a] = 0;
    end
    rtu_lat = 20;
    push_plane(6, 5, 1'b1);
    pulse_start(8'd6, 8'd5, t0);
    fork
      wait_done(2000);
      begin
        repeat (9) @(negedge clk);
        rtu_done_inj = 1'b1;
        @(negedge clk);
        rtu_done_inj = 1'b0;
        repeat (90) @(negedge clk);
        out_rows = 8'd4; out_cols = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    diff = 0;
    for (int a = 0; a < 30; a++) if (res_mem[a] !== res_snap[a]) diff++;
    n_vec++;
    if (diff !== 0) begin n_err++; $display("FAIL latency_contents: got %0d differing words, want 0", diff); end
    n_vec++;
    if (rs_cnt !== 4 || done_cnt !== 1 || wr_cnt !== 30 || rd_cnt !== 144) begin
      n_err++;
      $display("FAIL latency_counts: got rs %0d done %0d wr %0d rd %0d, want 4 1 30 144", rs_cnt, done_cnt, wr_cnt, rd_cnt);
    end
    n_vec++;
    if (done_cyc !== t0 + 1 + 4 * 75) begin
      n_err++;
      $display("FAIL latency_done_time: got %0d, want %0d", done_cyc, t0 + 1 + 4 * 75);
    end
  endtask

  task automatic test_reset_mid();
    int t0, wr_snap;
    clear_state();
    rtu_lat = 1;
    tbuf[2 * 6 + 2] = 16'd1;
    push_plane(4, 4, 1'b0);
    for (int n = 0; n < 16; n++) wr_q.push_back('{n, cb_exp[n]});
    pulse_start(8'd4, 8'd4, t0);
    for (int i = 0; i < 200 && cyc < t0 + 45; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, tb_rd_en, rtu_start, res_wr_en} !== 5'b0 || tb_rd_addr !== 18'd0 ||
        res_wr_addr !== 16'd0 || res_wr_data !== 16'd0 || rtu_matrix_in !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got strobes %b addr %0h/%0h data %0h, want all 0",
               {busy, done, tb_rd_en, rtu_start, res_wr_en}, tb_rd_addr, res_wr_addr, res_wr_data);
    end
    rst = 1'b0;
    wr_snap = wr_cnt;
    repeat (80) @(negedge clk);
    n_vec++;
    if (wr_cnt !== wr_snap || done_cnt !== 0 || wr_snap < 1 || wr_snap > 15) begin
      n_err++;
      $display("FAIL midreset_quiet: got wr %0d->%0d done %0d, want partial and unchanged, done 0",
               wr_snap, wr_cnt, done_cnt);
    end
    clear_state();
    for (int k = 0; k < 36; k++) tbuf[k] = 16'd1;
    push_plane(4, 4, 1'b0);
    for (int n = 0; n < 16; n++) wr_q.push_back('{n, ones_exp[n]});
    pulse_start(8'd4, 8'd4, t0);
    wait_done(500);
    n_vec++;
    if (done_cnt !== 1 || wr_cnt !== 16 || wr_q.size() !== 0) begin
      n_err++;
      $display("FAIL midreset_restart: got done %0d wr %0d left %0d, want 1 16 0", done_cnt, wr_cnt, wr_q.size());
    end
  endtask

  task automatic test_zero_dims();
    int t0;
    clear_state();
    pulse_start(8'd0, 8'd7, t0);
    wait_done(20);
    n_vec++;
    if (done_cnt !== 1 || done_cyc !== t0 + 1) begin
      n_err++;
      $display("FAIL zero_done: got count %0d cyc %0d, want 1 at %0d", done_cnt, done_cyc, t0 + 1);
    end
    n_vec++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || busy_cnt !== 0) begin
      n_err++;
      $display("FAIL zero_traffic: got rd %0d wr %0d busy %0d, want 0 0 0", rd_cnt, wr_cnt, busy_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_rows = '0; out_cols = '0; rtu_done_inj = 1'b0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0; rs_cnt = 0;
    first_rd = -1; first_rs = -1; done_cyc = -1;
    test_reset();
    test_impulse();
    test_ones();
    test_edge_clip();
    test_latency();
    test_reset_mid();
    test_zero_dims();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
